// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared encodings for the LED scan controller
package led_ctrl_pkg;
    localparam int NUM_LEDS = 4;
    localparam int SEL_W = 2;
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_RUN, ST_PAUSE} state_t;
endpackage

// File: rtl/led_scan_controller_sel_sequencer.sv
// sel_sequencer: owns the demux select and ping-pong direction
module sel_sequencer
    import led_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_l,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] manual_sel,
    input  logic             load_manual,
    input  logic             advance,
    input  logic             mode_chg,
    output logic [SEL_W-1:0] sel
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LEDS - 1);
    logic dir_up, go_up;
    logic [SEL_W-1:0] nxt;
    // pick the next select; ping-pong turns around at either end without repeating it
    always_comb begin
        go_up = dir_up ? (sel != LAST_SEL) : (sel == '0);
        nxt = (mode == MODE_PINGPONG && !go_up) ? sel - 1'b1 : sel + 1'b1;
    end
    // select follows the switches in manual mode, otherwise steps on each advance strike
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sel <= '0;
            dir_up <= 1'b1;
        end else begin
            if (load_manual) sel <= manual_sel;
            else if (advance) sel <= nxt;
            if (mode_chg) dir_up <= 1'b1;
            else if (advance && mode == MODE_PINGPONG) dir_up <= go_up;
        end
    end
endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: seeds/runs the LFSR and sequences the LED demux select
module led_scan_controller
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LFSR_BITS = 22,
    parameter logic [NUM_LFSR_BITS-1:0] SEED = NUM_LFSR_BITS'(1),
    parameter int DWELL_TICKS = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Slow_Pulse,
    input  logic [1:0]               i_Mode,
    input  logic [SEL_W-1:0]         i_Manual_Sel,
    input  logic                     i_Pause,
    output logic                     o_LFSR_Enable,
    output logic                     o_LFSR_Seed_DV,
    output logic [NUM_LFSR_BITS-1:0] o_LFSR_Seed_Data,
    output logic [SEL_W-1:0]         o_Sel,
    output logic                     o_Toggle,
    output logic                     o_Step
);
    localparam int CW = (DWELL_TICKS + 1 > 2) ? $clog2(DWELL_TICKS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);
    state_t state, state_nxt;
    logic [1:0] mode_q;
    logic [CW-1:0] cnt;
    logic accept, mode_chg, auto_mode, strike, load_manual;
    assign accept = state == ST_RUN && i_Slow_Pulse;
    assign mode_chg = i_Mode != mode_q;
    assign auto_mode = i_Mode == MODE_SCAN || i_Mode == MODE_PINGPONG;
    assign strike = accept && auto_mode && !mode_chg && cnt == LAST;
    assign load_manual = i_Mode == MODE_MANUAL && (state == ST_RUN || state == ST_PAUSE);
    assign o_LFSR_Enable = state == ST_RUN;
    assign o_LFSR_Seed_DV = state == ST_SEED;
    assign o_LFSR_Seed_Data = SEED;
    // IDLE and SEED each last one cycle, then pause level alone moves between RUN and PAUSE
    always_comb begin
        state_nxt = state == ST_IDLE ? ST_SEED : state == ST_SEED ? ST_RUN : i_Pause ? ST_PAUSE : ST_RUN;
    end
    // state, dwell count, toggle and step strobe; a mode change restarts the dwell
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
            mode_q <= MODE_MANUAL;
            cnt <= '0;
            o_Toggle <= 1'b0;
            o_Step <= 1'b0;
        end else begin
            state <= state_nxt;
            mode_q <= i_Mode;
            o_Step <= strike;
            if (accept) o_Toggle <= ~o_Toggle;
            if (mode_chg || i_Mode == MODE_MANUAL) cnt <= '0;
            else if (accept && auto_mode) cnt <= strike ? '0 : cnt + 1'b1;
        end
    end
    sel_sequencer u_seq (
        .clk(i_Clk),
        .rst_l(i_Rst_L),
        .mode(i_Mode),
        .manual_sel(i_Manual_Sel),
        .load_manual(load_manual),
        .advance(strike),
        .mode_chg(mode_chg),
        .sel(o_Sel)
    );
endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: directed vectors checked through an expected-output scoreboard
module tb_led_scan_controller;
    logic clk = 1'b0;
    logic rst_l, pulse, pause;
    logic [1:0] mode, msel;
    logic en, dv, tog, stp, en1, dv1, tog1, stp1;
    logic [1:0] sel, sel1;
    logic [21:0] seed, seed1;
    int vectors = 0;
    int miscompares = 0;
    typedef struct {
        string name;
        logic en, dv;
        logic [1:0] sel;
        logic tog, stp;
        bit chk1;
        logic [1:0] sel1;
        logic stp1;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    bit bad;

    always #5 clk = ~clk;

    led_scan_controller #(.NUM_LFSR_BITS(22), .SEED(22'd1), .DWELL_TICKS(4)) dut4 (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Slow_Pulse(pulse), .i_Mode(mode),
        .i_Manual_Sel(msel), .i_Pause(pause), .o_LFSR_Enable(en), .o_LFSR_Seed_DV(dv),
        .o_LFSR_Seed_Data(seed), .o_Sel(sel), .o_Toggle(tog), .o_Step(stp)
    );
    led_scan_controller #(.NUM_LFSR_BITS(22), .SEED(22'd1), .DWELL_TICKS(1)) dut1 (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Slow_Pulse(pulse), .i_Mode(mode),
        .i_Manual_Sel(msel), .i_Pause(pause), .o_LFSR_Enable(en1), .o_LFSR_Seed_DV(dv1),
        .o_LFSR_Seed_Data(seed1), .o_Sel(sel1), .o_Toggle(tog1), .o_Step(stp1)
    );

    // drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic v(input string n, input logic r, p, ps, input logic [1:0] m, ms,
                     input logic xe, xd, input logic [1:0] xs, input logic xt, xst,
                     input bit c1, input logic [1:0] xs1, input logic xst1);
        exp_t x;
        rst_l = r; pulse = p; pause = ps; mode = m; msel = ms;
        x.name = n; x.en = xe; x.dv = xd; x.sel = xs; x.tog = xt; x.stp = xst;
        x.chk1 = c1; x.sel1 = xs1; x.stp1 = xst1;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // monitor: after every edge, pop the oldest expectation and compare
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            bad = en !== e.en || dv !== e.dv || sel !== e.sel || tog !== e.tog ||
                  stp !== e.stp || seed !== 22'd1 || seed1 !== 22'd1;
            if (e.chk1) bad = bad || sel1 !== e.sel1 || stp1 !== e.stp1;
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got en=%b dv=%b sel=%0d tog=%b step=%b seed=%0h sel1=%0d step1=%b; want en=%b dv=%b sel=%0d tog=%b step=%b seed=1 sel1=%0d step1=%b (chk1=%0d)",
                         e.name, en, dv, sel, tog, stp, seed, sel1, stp1,
                         e.en, e.dv, e.sel, e.tog, e.stp, e.sel1, e.stp1, e.chk1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sc_sel [16] = '{0,0,0,1, 1,1,1,2, 2,2,2,3, 3,3,3,0};
        logic       sc_stp [16] = '{0,0,0,1, 0,0,0,1, 0,0,0,1, 0,0,0,1};
        logic [1:0] pp_sel [8]  = '{0,0,0,1, 1,1,1,2};
        logic       pp_stp [8]  = '{0,0,0,1, 0,0,0,1};
        logic [1:0] pp_sel1 [8] = '{1,2,3,2, 1,0,1,2};
        rst_l = 1'b0; pulse = 1'b0; pause = 1'b0; mode = 2'b01; msel = 2'b00;
        @(negedge clk);
        v("rst0",      0,1,0,2'd1,2'd0, 0,0,2'd0,0,0, 1,2'd0,0);
        v("rst1",      0,1,0,2'd1,2'd0, 0,0,2'd0,0,0, 1,2'd0,0);
        v("seed",      1,1,0,2'd1,2'd0, 0,1,2'd0,0,0, 1,2'd0,0);
        v("run",       1,1,0,2'd1,2'd0, 1,0,2'd0,0,0, 1,2'd0,0);
        for (int k = 0; k < 16; k++)
            v("scan",  1,1,0,2'd1,2'd0, 1,0,sc_sel[k],(k % 2 == 0),sc_stp[k], 0,2'd0,0);
        v("scan_idle", 1,0,0,2'd1,2'd0, 1,0,2'd0,0,0, 0,2'd0,0);
        v("pa_pulse",  1,1,0,2'd1,2'd0, 1,0,2'd0,1,0, 0,2'd0,0);
        v("pa_enter",  1,1,1,2'd1,2'd0, 0,0,2'd0,0,0, 0,2'd0,0);
        for (int k = 0; k < 3; k++)
            v("pa_hold", 1,1,1,2'd1,2'd0, 0,0,2'd0,0,0, 0,2'd0,0);
        v("pa_release",1,0,0,2'd1,2'd0, 1,0,2'd0,0,0, 0,2'd0,0);
        v("pa_resume", 1,1,0,2'd1,2'd0, 1,0,2'd0,1,0, 0,2'd0,0);
        v("pa_adv",    1,1,0,2'd1,2'd0, 1,0,2'd1,0,1, 0,2'd0,0);
        v("pa_idle",   1,0,0,2'd1,2'd0, 1,0,2'd1,0,0, 0,2'd0,0);
        v("ms_p1",     1,1,0,2'd1,2'd0, 1,0,2'd1,1,0, 0,2'd0,0);
        v("ms_p2",     1,1,0,2'd1,2'd0, 1,0,2'd1,0,0, 0,2'd0,0);
        v("ms_hold",   1,0,0,2'd3,2'd0, 1,0,2'd1,0,0, 0,2'd0,0);
        v("ms_hp1",    1,1,0,2'd3,2'd0, 1,0,2'd1,1,0, 0,2'd0,0);
        v("ms_hp2",    1,1,0,2'd3,2'd0, 1,0,2'd1,0,0, 0,2'd0,0);
        v("ms_back",   1,0,0,2'd1,2'd0, 1,0,2'd1,0,0, 0,2'd0,0);
        v("ms_q1",     1,1,0,2'd1,2'd0, 1,0,2'd1,1,0, 0,2'd0,0);
        v("ms_q2",     1,1,0,2'd1,2'd0, 1,0,2'd1,0,0, 0,2'd0,0);
        v("ms_q3",     1,1,0,2'd1,2'd0, 1,0,2'd1,1,0, 0,2'd0,0);
        v("ms_q4",     1,1,0,2'd1,2'd0, 1,0,2'd2,0,1, 0,2'd0,0);
        v("ms_idle",   1,0,0,2'd1,2'd0, 1,0,2'd2,0,0, 0,2'd0,0);
        v("man0",      1,0,0,2'd0,2'd0, 1,0,2'd0,0,0, 0,2'd0,0);
        v("man3",      1,0,0,2'd0,2'd3, 1,0,2'd3,0,0, 0,2'd0,0);
        v("man1",      1,1,0,2'd0,2'd1, 1,0,2'd1,1,0, 0,2'd0,0);
        v("man2",      1,0,0,2'd0,2'd2, 1,0,2'd2,1,0, 0,2'd0,0);
        v("mrst",      0,0,0,2'd2,2'd0, 0,0,2'd0,0,0, 1,2'd0,0);
        v("mseed",     1,1,0,2'd2,2'd0, 0,1,2'd0,0,0, 1,2'd0,0);
        v("mrun",      1,1,0,2'd2,2'd0, 1,0,2'd0,0,0, 1,2'd0,0);
        for (int k = 0; k < 8; k++)
            v("pingpong", 1,1,0,2'd2,2'd0, 1,0,pp_sel[k],(k % 2 == 0),pp_stp[k], 1,pp_sel1[k],1);
        v("pp_idle",   1,0,0,2'd2,2'd0, 1,0,2'd2,0,0, 1,2'd2,0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
